// File: rtl/add_reduce_if.sv
// ---------------------------------------------------------------------------
// add_reduce_if
// Bundles the operand-load strobe, the packed operand bus and the result side
// of add_reduce.
//
// Handshake semantics: r_enable is a single-cycle load strobe with no ready;
// it is accepted on every rising edge where it is high, in any state, and
// aborts any reduction in progress. w_enable is a level-valid: while it is
// high, result (and ovf) are final and stable, and they stay so until the
// next accepted load. busy is high exactly while a reduction is running.
//
// Parameters: N_IN operands of IN_W bits, OUT_W-bit result.
// Signals:
//   r_enable  : load/start strobe (master -> slave)
//   init_vals : N_IN*IN_W packed operands, operand i at [i*IN_W +: IN_W]
//   busy      : reduction in progress (slave -> master)
//   w_enable  : result valid level (slave -> master)
//   result    : final sum (slave -> master)
//   ovf       : sticky saturation flag (slave -> master)
// ---------------------------------------------------------------------------
interface add_reduce_if #(
    parameter int N_IN  = 7,
    parameter int IN_W  = 10,
    parameter int OUT_W = IN_W + $clog2(N_IN)
);
    logic                   r_enable;
    logic [N_IN*IN_W-1:0]   init_vals;
    logic                   busy;
    logic                   w_enable;
    logic [OUT_W-1:0]       result;
    logic                   ovf;

    modport master (
        output r_enable, init_vals,
        input  busy, w_enable, result, ovf
    );

    modport slave (
        input  r_enable, init_vals,
        output busy, w_enable, result, ovf
    );
endinterface

// File: rtl/add_reduce.sv
// ---------------------------------------------------------------------------
// add_reduce
// Resource-shared multi-operand adder. A load captures N_IN operands
// (sign- or zero-extended to OUT_W), then each cycle up to N_ADD adjacent
// pairs are summed and the remaining live values are compacted down, until
// a single value is left. That value is presented on result with w_enable
// held high until the next load.
//
// Optional feature macro: ADD_REDUCE_SAT_EN
//   defined   : every add saturates to the OUT_W range, sticky ovf flag
//   undefined : adds wrap modulo 2^OUT_W, ovf tied to 0
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : add_reduce_if.slave (r_enable, init_vals, busy,
//                 w_enable, result, ovf)
//   dbg_state_o : FSM state for observation (0 = IDLE, 1 = RUN, 2 = DONE)
// ---------------------------------------------------------------------------
module add_reduce #(
    parameter int N_IN   = 7,
    parameter int IN_W   = 10,
    parameter int OUT_W  = IN_W + $clog2(N_IN),
    parameter int N_ADD  = 1,
    parameter int SIGNED = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    add_reduce_if.slave bus,
    output logic [1:0]  dbg_state_o
);
    localparam int KW   = $clog2(N_IN + 1);
    localparam int HALF = N_IN / 2;
    // Adders beyond floor(N_IN/2) could never be used.
    localparam int NA   = (N_ADD < HALF) ? N_ADD : HALF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             we_q;
    logic [OUT_W-1:0] res_q;
    logic [OUT_W-1:0] v_q  [N_IN];
    logic [OUT_W-1:0] v_d  [N_IN];
    logic [OUT_W-1:0] ld_v [N_IN];
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_d;
    logic [KW-1:0]    p;

`ifdef ADD_REDUCE_SAT_EN
    logic             ovf_q;
    logic             step_ovf;
    logic [OUT_W:0]   sum_t;

    // Returns {overflowed, saturated_sum}.
    function automatic logic [OUT_W:0] sat_add(input logic [OUT_W-1:0] a,
                                               input logic [OUT_W-1:0] b);
        logic [OUT_W:0]   s;
        logic [OUT_W-1:0] r;
        logic             o;
        s = {1'b0, a} + {1'b0, b};
        r = s[OUT_W-1:0];
        o = 1'b0;
        if (SIGNED != 0) begin
            // Signed overflow: equal operand signs, different result sign.
            if ((a[OUT_W-1] == b[OUT_W-1]) && (r[OUT_W-1] != a[OUT_W-1])) begin
                o = 1'b1;
                if (a[OUT_W-1]) begin
                    r = '0;
                    r[OUT_W-1] = 1'b1;
                end else begin
                    r = '1;
                    r[OUT_W-1] = 1'b0;
                end
            end
        end else if (s[OUT_W]) begin
            o = 1'b1;
            r = '1;
        end
        return {o, r};
    endfunction
`endif

    // Operand extension for the load path.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            if (SIGNED != 0) begin
                ld_v[i] = OUT_W'($signed(bus.init_vals[i*IN_W +: IN_W]));
            end else begin
                ld_v[i] = OUT_W'(bus.init_vals[i*IN_W +: IN_W]);
            end
        end
    end

    // One reduction step: pairs (2j, 2j+1) for j < p land in slot j, and the
    // untouched tail v[2p..k-1] slides down by p, keeping operand order.
    always_comb begin
        v_d = v_q;
`ifdef ADD_REDUCE_SAT_EN
        step_ovf = 1'b0;
        sum_t    = '0;
`endif
        p   = ((k_q >> 1) < KW'(NA)) ? (k_q >> 1) : KW'(NA);
        for (int j = 0; j < N_IN; j++) begin
            if ((j >= int'(p)) && (j + int'(p) < int'(k_q))) begin
                v_d[j] = v_q[j + int'(p)];
            end
        end
        for (int j = 0; j < NA; j++) begin
            if (j < int'(p)) begin
`ifdef ADD_REDUCE_SAT_EN
                sum_t    = sat_add(v_q[2*j], v_q[2*j+1]);
                v_d[j]   = sum_t[OUT_W-1:0];
                step_ovf = step_ovf | sum_t[OUT_W];
`else
                v_d[j] = v_q[2*j] + v_q[2*j+1];
`endif
            end
        end
        k_d = k_q - p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            res_q   <= '0;
            k_q     <= '0;
            for (int i = 0; i < N_IN; i++) begin
                v_q[i] <= '0;
            end
`ifdef ADD_REDUCE_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else if (bus.r_enable) begin
            // A load wins in every state and drops any running reduction.
            v_q <= ld_v;
            k_q <= KW'(N_IN);
`ifdef ADD_REDUCE_SAT_EN
            ovf_q <= 1'b0;
`endif
            if (N_IN == 1) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                we_q    <= 1'b1;
                res_q   <= ld_v[0];
            end else begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                we_q    <= 1'b0;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    v_q <= v_d;
                    k_q <= k_d;
`ifdef ADD_REDUCE_SAT_EN
                    ovf_q <= ovf_q | step_ovf;
`endif
                    if (k_d == KW'(1)) begin
                        res_q   <= v_d[0];
                        we_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE hold until the next load.
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.w_enable = we_q;
    assign bus.result   = res_q;
`ifdef ADD_REDUCE_SAT_EN
    assign bus.ovf      = ovf_q;
`else
    assign bus.ovf      = 1'b0;
`endif
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_add_reduce.sv
// ---------------------------------------------------------------------------
// tb_add_reduce
// Five add_reduce instances (N_IN=7, IN_W=10) share one clock and reset:
//   u0: N_ADD=1 unsigned, u1: N_ADD=2 unsigned, u2: N_ADD=4 unsigned,
//   u3: N_ADD=2 signed, u4: N_ADD=1 unsigned with OUT_W=10.
// A behavioural model tracks each instance from the operand sum and the
// schedule's step count; a compare process checks every cycle, and directed
// tests pin latencies and sums with literal values.
// ---------------------------------------------------------------------------
module tb_add_reduce;
    logic clk;
    logic rst_n;

    add_reduce_if #(.N_IN(7), .IN_W(10), .OUT_W(13)) if0 (), if1 (), if2 (), if3 ();
    add_reduce_if #(.N_IN(7), .IN_W(10), .OUT_W(10)) if4 ();

    logic [1:0]  dbg_a  [5];
    logic        re     [5];
    logic [69:0] iv     [5];
    logic        busy_a [5];
    logic        we_a   [5];
    logic        ovf_a  [5];
    logic [12:0] res_a  [5];

    add_reduce #(.N_IN(7), .IN_W(10), .OUT_W(13), .N_ADD(1), .SIGNED(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .dbg_state_o(dbg_a[0]));
    add_reduce #(.N_IN(7), .IN_W(10), .OUT_W(13), .N_ADD(2), .SIGNED(0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .dbg_state_o(dbg_a[1]));
    add_reduce #(.N_IN(7), .IN_W(10), .OUT_W(13), .N_ADD(4), .SIGNED(0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .dbg_state_o(dbg_a[2]));
    add_reduce #(.N_IN(7), .IN_W(10), .OUT_W(13), .N_ADD(2), .SIGNED(1)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3), .dbg_state_o(dbg_a[3]));
    add_reduce #(.N_IN(7), .IN_W(10), .OUT_W(10), .N_ADD(1), .SIGNED(0)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .dbg_state_o(dbg_a[4]));

    assign if0.r_enable = re[0];  assign if0.init_vals = iv[0];
    assign if1.r_enable = re[1];  assign if1.init_vals = iv[1];
    assign if2.r_enable = re[2];  assign if2.init_vals = iv[2];
    assign if3.r_enable = re[3];  assign if3.init_vals = iv[3];
    assign if4.r_enable = re[4];  assign if4.init_vals = iv[4];

    assign busy_a[0] = if0.busy;  assign we_a[0] = if0.w_enable;
    assign busy_a[1] = if1.busy;  assign we_a[1] = if1.w_enable;
    assign busy_a[2] = if2.busy;  assign we_a[2] = if2.w_enable;
    assign busy_a[3] = if3.busy;  assign we_a[3] = if3.w_enable;
    assign busy_a[4] = if4.busy;  assign we_a[4] = if4.w_enable;
    assign ovf_a[0]  = if0.ovf;   assign res_a[0] = if0.result;
    assign ovf_a[1]  = if1.ovf;   assign res_a[1] = if1.result;
    assign ovf_a[2]  = if2.ovf;   assign res_a[2] = if2.result;
    assign ovf_a[3]  = if3.ovf;   assign res_a[3] = if3.result;
    assign ovf_a[4]  = if4.ovf;   assign res_a[4] = {3'b000, if4.result};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- per-instance configuration ----------------
    int n_add_c [5] = '{1, 2, 4, 2, 1};
    int outw_c  [5] = '{13, 13, 13, 13, 10};
    bit sgn_c   [5] = '{0, 0, 0, 1, 0};

    int seq17 [7] = '{1, 2, 3, 4, 5, 6, 7};
    int seq10 [7] = '{10, 10, 10, 10, 10, 10, 10};
    int seqsg [7] = '{-512, 511, -1, 0, 3, -3, 100};
    int seqmx [7] = '{1023, 1023, 1023, 1023, 1023, 1023, 1023};

    int n_pass;
    int n_total;
    bit chk_en;

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[u%0d]: got %0d, expected %0d", name, k, act, exp);
    endtask

    function automatic logic [69:0] pack(input int a[7]);
        logic [69:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r[i*10 +: 10] = 10'(a[i]);
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // Steps needed: each step retires min(N_ADD, floor(k/2)) live values.
    function automatic int lat(input int na);
        int k;
        int steps;
        int p;
        k = 7;
        steps = 0;
        while (k > 1) begin
            p = (na < k / 2) ? na : k / 2;
            k = k - p;
            steps++;
        end
        return steps;
    endfunction

    function automatic void model_sum(input int k, input logic [69:0] v,
                                      output logic [12:0] s, output logic o);
        longint tot;
        longint maxv;
        longint minv;
        logic [9:0] op;
        int w;
        w   = outw_c[k];
        tot = 0;
        for (int i = 0; i < 7; i++) begin
            op = v[i*10 +: 10];
            if (sgn_c[k]) tot = tot + longint'($signed(op));
            else          tot = tot + longint'(op);
        end
        maxv = sgn_c[k] ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
        minv = sgn_c[k] ? -(longint'(1) << (w - 1)) : 0;
        o = 1'b0;
`ifdef ADD_REDUCE_SAT_EN
        if (tot > maxv) begin
            tot = maxv;
            o = 1'b1;
        end else if (tot < minv) begin
            tot = minv;
            o = 1'b1;
        end
`endif
        s = 13'(tot & ((longint'(1) << w) - 1));
    endfunction

    int          m_st   [5];   // 0 idle, 1 run, 2 done
    int          m_left [5];
    logic [12:0] m_res  [5];
    logic        m_ovf  [5];
    logic [12:0] m_pend [5];
    logic        m_povf [5];

    initial begin
        for (int k = 0; k < 5; k++) begin
            m_st[k] = 0; m_left[k] = 0; m_res[k] = '0; m_ovf[k] = 1'b0;
            m_pend[k] = '0; m_povf[k] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 5; k++) begin
                if (!rst_n) begin
                    m_st[k] = 0; m_left[k] = 0; m_res[k] = '0; m_ovf[k] = 1'b0;
                end else if (re[k]) begin
                    model_sum(k, iv[k], m_pend[k], m_povf[k]);
                    m_left[k] = lat(n_add_c[k]);
                    m_st[k]   = 1;
                    m_ovf[k]  = 1'b0;
                end else if (m_st[k] == 1) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_st[k]  = 2;
                        m_res[k] = m_pend[k];
                        m_ovf[k] = m_povf[k];
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 5; k++) begin
                    chk("busy", k, busy_a[k], (m_st[k] == 1) ? 1 : 0);
                    chk("w_enable", k, we_a[k], (m_st[k] == 2) ? 1 : 0);
                    chk("state", k, dbg_a[k], m_st[k]);
                    if (m_st[k] != 1) begin
                        chk("result", k, res_a[k], m_res[k]);
                        chk("ovf", k, ovf_a[k], m_ovf[k]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int lat_m  [5];
    int bsy_m  [5];

    // Called at the negedge right after the loading edge.
    task automatic measure(input bit [4:0] mask, input int max_c);
        bit all_done;
        for (int k = 0; k < 5; k++) begin
            lat_m[k] = -1;
            bsy_m[k] = 0;
        end
        for (int c = 0; c <= max_c; c++) begin
            all_done = 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (mask[k] && lat_m[k] < 0) begin
                    if (busy_a[k]) bsy_m[k]++;
                    if (we_a[k]) lat_m[k] = c;
                    else all_done = 1'b0;
                end
            end
            if (all_done) break;
            @(negedge clk);
        end
    endtask

    task automatic pulse(input int k, input logic [69:0] v);
        iv[k] = v;
        re[k] = 1'b1;
        @(negedge clk);
        re[k] = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 5; k++) begin
            chk({tag, "_busy"}, k, busy_a[k], 0);
            chk({tag, "_we"}, k, we_a[k], 0);
            chk({tag, "_result"}, k, res_a[k], 0);
            chk({tag, "_ovf"}, k, ovf_a[k], 0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_pass  = 0;
        n_total = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            re[k] = 1'b0;
            iv[k] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All five instances load on the same edge.
        iv[0] = pack(seq17); iv[1] = pack(seq17); iv[2] = pack(seq17);
        iv[3] = pack(seqsg); iv[4] = pack(seqmx);
        for (int k = 0; k < 5; k++) re[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) re[k] = 1'b0;
        measure(5'b11111, 20);
        chk("lat_nadd1", 0, lat_m[0], 6);
        chk("lat_nadd2", 1, lat_m[1], 4);
        chk("lat_nadd4", 2, lat_m[2], 3);
        chk("lat_signed", 3, lat_m[3], 4);
        chk("lat_w10", 4, lat_m[4], 6);
        chk("busy_cycles", 0, bsy_m[0], 6);
        chk("busy_cycles", 1, bsy_m[1], 4);
        chk("busy_cycles", 2, bsy_m[2], 3);
        @(negedge clk);
        chk("sum_1to7", 0, res_a[0], 28);
        chk("sum_1to7", 1, res_a[1], 28);
        chk("sum_1to7", 2, res_a[2], 28);
        chk("sum_signed", 3, res_a[3], 98);
        chk("ovf_signed", 3, ovf_a[3], 0);
`ifdef ADD_REDUCE_SAT_EN
        chk("sum_sat", 4, res_a[4], 1023);
        chk("ovf_sat", 4, ovf_a[4], 1);
`else
        chk("sum_wrap", 4, res_a[4], 1017);
        chk("ovf_wrap", 4, ovf_a[4], 0);
`endif
        repeat (3) @(negedge clk);
        chk("hold_we", 0, we_a[0], 1);
        chk("hold_result", 0, res_a[0], 28);

        // Restart two cycles into a reduction.
        pulse(0, pack(seq17));
        @(negedge clk);
        pulse(0, pack(seq10));
        measure(5'b00001, 20);
        chk("restart_lat", 0, lat_m[0], 6);
        chk("restart_sum", 0, res_a[0], 70);

        // r_enable held high reloads and makes no progress.
        iv[1] = pack(seq10);
        re[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_we", 1, we_a[1], 0);
        re[1] = 1'b0;
        measure(5'b00010, 20);
        chk("held_lat", 1, lat_m[1], 4);
        chk("held_sum", 1, res_a[1], 70);

        // Asynchronous reset in the middle of a reduction.
        pulse(0, pack(seq17));
        @(negedge clk);
        chk("pre_reset_busy", 0, busy_a[0], 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        iv[0] = pack(seq17);
        re[0] = 1'b1;
        @(negedge clk);
        re[0] = 1'b0;
        measure(5'b00001, 20);
        chk("post_reset_lat", 0, lat_m[0], 6);
        chk("post_reset_sum", 0, res_a[0], 28);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/add_reduce.md
# add_reduce

Parametrised, resource-shared multi-operand adder for the scheduled-datapath family. It loads `N_IN` operands in one cycle on `r_enable`, then reduces them using at most `N_ADD` two-input adders per cycle, on a fixed deterministic schedule. It raises `w_enable` with the final sum and holds it until the next load. It generalises the fixed single-adder 7-operand sum: operand count, width, adder count and signedness are all parameters, and it adds a busy indication, restart and asynchronous reset.

## Interface
- `N_IN`, default 7: number of operands, ≥1.
- `IN_W`, default 10: operand width.
- `OUT_W`, default `IN_W+$clog2(N_IN)`: accumulator and result width; must be ≥`IN_W`.
- `N_ADD`, default 1: adders instantiated, ≥1; adders beyond `N_IN/2` are unused.
- `SIGNED`, default 0: 1 = two's-complement operands, sign-extended; 0 = zero-extended.
- `clk`: input, 1 bit, sole clock, rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `r_enable`: input, 1 bit, load/start strobe, sampled each rising edge.
- `init_vals`: input, `N_IN*IN_W` bits. Operand i is at `[i*IN_W +: IN_W]`.
- `busy`: output, 1 bit, high while reducing.
- `w_enable`: output, 1 bit, result valid (level).
- `result`: output, `OUT_W` bits, final sum.
- `ovf`: output, 1 bit, sticky overflow flag; constant 0 unless `ADD_REDUCE_SAT_EN` is defined.

## Operation
- Internal state:
  - value array `v[0..N_IN-1]`, each `OUT_W` bits;
  - live count `k`;
  - FSM with states IDLE, RUN, DONE.
- Load: on an edge with `r_enable`=1, in any state, and regardless of whether a reduction is in progress:
  - `v[i]` ← extended operand i;
  - `k` ← `N_IN`;
  - `w_enable` ← 0, `ovf` ← 0;
  - state ← RUN, or DONE directly if `N_IN`=1 (then `result` ← `v[0]` and `w_enable` ← 1 on that same edge).
  - A load mid-reduction aborts it; no stale result is ever presented.
- RUN step, once per edge with `r_enable`=0:
  - p = min(`N_ADD`, floor(k/2));
  - for j<p: `v[j]` ← `v[2j]` + `v[2j+1]`;
  - for m in 2p..k-1: `v[m-p]` ← `v[m]` (order preserved);
  - `k` ← k−p.
- Completion: on the step where the new `k` equals 1:
  - `result` ← the new `v[0]`;
  - `w_enable` ← 1;
  - state ← DONE.
- DONE: holds `result`, `w_enable`=1 and `ovf` until the next load. No other transitions.
- IDLE: entered only from reset; leaves only on `r_enable`.
- `busy` = (state==RUN), registered alongside the state.
- Arithmetic: every add is `OUT_W` bits wide. Without the macro, it wraps modulo 2^`OUT_W`; the default `OUT_W` cannot overflow.

## Timing
- Reset (`rst_n`=0, asynchronous assert) forces:
  - state IDLE;
  - `busy`=0, `w_enable`=0, `ovf`=0, `result`=0;
  - `v` and `k` cleared.
- Reset mid-RUN discards all work. Deassertion is synchronised externally; the first edge after release may carry `r_enable`.
- Latency L = number of RUN steps, from the loading edge to the edge that raises `w_enable`:
  - `N_IN`=7: `N_ADD`=1 → 6, `N_ADD`=2 → 4 (k 7,5,3,2,1), `N_ADD`≥3 → 3 (k 7,4,2,1);
  - general case with `N_ADD`=1: L=`N_IN`−1.
- `busy` is high for exactly L cycles.
- `r_enable` held high reloads every edge; no progress is made.
- `init_vals` is sampled only on the loading edge.

## Configuration
- `ADD_REDUCE_SAT_EN` defined:
  - each add saturates to the representable `OUT_W` range: [0, 2^`OUT_W`−1] unsigned, [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1] signed;
  - any saturating add sets sticky `ovf`, which is cleared on load or reset.
- Not defined:
  - adds wrap;
  - `ovf` tied to 0;
  - no saturation logic synthesised.

## Test plan
- `N_IN`=7, `IN_W`=10, `N_ADD`=1, operands 1..7, one `r_enable` pulse → `busy` high 6 cycles; `w_enable` rises 6 edges after load; `result`=28; held until next load.
- Same operands with `N_ADD`=2 → `result`=28 after 4 edges; with `N_ADD`=4 → 28 after 3 edges.
- `SIGNED`=1, `N_ADD`=2, operands {−512, 511, −1, 0, 3, −3, 100} → `result`=98, `ovf`=0.
- Restart: load 1..7, then pulse `r_enable` with all operands 10 two cycles later (`N_ADD`=1) → `w_enable` stays 0 until 6 edges after the second load; `result`=70.
- `rst_n` asserted asynchronously mid-RUN → all outputs 0 immediately. After release, a load of 1..7 → 28 with normal latency.
- `OUT_W`=10, unsigned, all operands 1023, `N_ADD`=1 → with `ADD_REDUCE_SAT_EN`: `result`=1023, `ovf`=1. Without it: `result`=1017, `ovf`=0.
